// File: rtl/instruction_fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction fetch queue.
// master = fetch/decode side driving the queue, slave = the queue itself.
interface instruction_fetch_queue_if #(
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned DEPTH      = 8
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                  flush;
  logic                  wr_valid;
  logic [INST_WIDTH-1:0] wr_inst;
  logic [PC_WIDTH-1:0]   wr_pc;
  logic                  wr_ready;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [INST_WIDTH-1:0] rd_inst;
  logic [PC_WIDTH-1:0]   rd_pc;
  logic [CntW-1:0]       count;
  logic                  empty;
  logic                  full;
  logic                  almost_full;

  modport master (
    output flush, wr_valid, wr_inst, wr_pc, rd_ready,
    input  wr_ready, rd_valid, rd_inst, rd_pc, count, empty, full, almost_full
  );

  modport slave (
    input  flush, wr_valid, wr_inst, wr_pc, rd_ready,
    output wr_ready, rd_valid, rd_inst, rd_pc, count, empty, full, almost_full
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Circular-buffer instruction queue between fetch and decode: first-word-fall-through head,
// wrap-bit pointers, flush for redirects. Storage is never cleared, only the pointers.
module instruction_fetch_queue #(
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AF_THRESH  = DEPTH - 2
) (
  input logic                      clk,
  input logic                      rst_n,
  instruction_fetch_queue_if.slave ifq
);
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam logic [PtrW-1:0] AfThresh = PtrW'(AF_THRESH);

  logic [INST_WIDTH-1:0] mem_inst [DEPTH];
  logic [PC_WIDTH-1:0]   mem_pc   [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] count_w;
  logic            empty_w, full_w;
  logic            wr_fire, rd_fire;

  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
                   (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);
  assign count_w = wr_ptr_q - rd_ptr_q;

  // wr_ready deliberately ignores rd_ready: no write-through when full.
  assign wr_fire = ifq.wr_valid && !full_w && !ifq.flush;
  assign rd_fire = ifq.rd_ready && !empty_w && !ifq.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (ifq.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (rd_fire) rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // A slot written while reset is held is harmless: the write pointer does not advance.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_inst[wr_ptr_q[AddrW-1:0]] <= ifq.wr_inst;
      mem_pc[wr_ptr_q[AddrW-1:0]]   <= ifq.wr_pc;
    end
  end

  assign ifq.wr_ready    = !full_w;
  assign ifq.rd_valid    = !empty_w;
  assign ifq.rd_inst     = mem_inst[rd_ptr_q[AddrW-1:0]];
  assign ifq.rd_pc       = mem_pc[rd_ptr_q[AddrW-1:0]];
  assign ifq.count       = count_w;
  assign ifq.empty       = empty_w;
  assign ifq.full        = full_w;
  assign ifq.almost_full = (count_w >= AfThresh);

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed scoreboard bench for instruction_fetch_queue (DEPTH=8, AF_THRESH=6).
module tb_instruction_fetch_queue;
  localparam int unsigned Depth = 8;
  localparam int unsigned AfTh  = 6;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  entry_t sb[$];

  instruction_fetch_queue_if #(.INST_WIDTH(32), .PC_WIDTH(32), .DEPTH(Depth)) bus ();

  instruction_fetch_queue #(
    .INST_WIDTH(32),
    .PC_WIDTH  (32),
    .DEPTH     (Depth),
    .AF_THRESH (AfTh)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ifq  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Flags and head checked against the scoreboard's own occupancy.
  task automatic chk_state(input string tag);
    int unsigned n;
    n = sb.size();
    chk({tag, ".count"}, 64'(bus.count), 64'(n));
    chk({tag, ".empty"}, 64'(bus.empty), 64'(n == 0));
    chk({tag, ".full"}, 64'(bus.full), 64'(n == Depth));
    chk({tag, ".af"}, 64'(bus.almost_full), 64'(n >= AfTh));
    chk({tag, ".wr_ready"}, 64'(bus.wr_ready), 64'(n != Depth));
    chk({tag, ".rd_valid"}, 64'(bus.rd_valid), 64'(n != 0));
    if (n != 0) begin
      chk({tag, ".rd_inst"}, 64'(bus.rd_inst), 64'(sb[0].inst));
      chk({tag, ".rd_pc"}, 64'(bus.rd_pc), 64'(sb[0].pc));
    end
  endtask

  // Called just after a rising edge: drive, check mid-cycle, advance the model, clock.
  task automatic tick(input string tag, input logic wv, input logic [31:0] wi,
                      input logic [31:0] wp, input logic rr, input logic fl);
    bit do_wr, do_rd;
    bus.wr_valid = wv;
    bus.wr_inst  = wi;
    bus.wr_pc    = wp;
    bus.rd_ready = rr;
    bus.flush    = fl;
    #3;
    chk_state(tag);
    do_wr = wv && (sb.size() < Depth);
    do_rd = rr && (sb.size() > 0);
    if (fl) begin
      sb.delete();
    end else begin
      if (do_rd) void'(sb.pop_front());
      if (do_wr) sb.push_back('{inst: wi, pc: wp});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.flush    = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_inst  = '0;
    bus.wr_pc    = '0;
    bus.rd_ready = 1'b0;

    // Async reset before any clock edge.
    #2 rst_n = 1'b1;
    #1 chk_state("reset");
    @(posedge clk);
    #1 rst_n = 1'b0;

    // Fill with rd_ready low, then a 9th write that must be ignored.
    for (int i = 0; i < 8; i++) tick("fill", 1'b1, 32'h100 + i, 32'(4 * i), 1'b0, 1'b0);
    tick("fill9", 1'b1, 32'hDEAD, 32'hFC, 1'b0, 1'b0);
    chk_state("full");
    // Read + write while full: read fires, write refused.
    tick("full_rw", 1'b1, 32'hBEEF, 32'hF8, 1'b1, 1'b0);
    chk("full_rw.count", 64'(bus.count), 64'(Depth - 1));

    // Drain continuously, then idle reads on an empty queue have no effect.
    for (int i = 0; i < 9; i++) tick("drain", 1'b0, '0, '0, 1'b1, 1'b0);
    chk_state("drained");

    // Write when empty: count becomes 1 next cycle.
    tick("wr_empty", 1'b1, 32'h200, 32'h1000, 1'b1, 1'b0);
    chk("wr_empty.count", 64'(bus.count), 64'd1);
    for (int i = 1; i < 4; i++) tick("load4", 1'b1, 32'h200 + i, 32'h1000 + 32'(4 * i), 1'b0, 1'b0);

    // Stall at count 4.
    for (int i = 0; i < 3; i++) tick("stall", 1'b0, '0, '0, 1'b0, 1'b0);
    chk("stall.inst", 64'(bus.rd_inst), 64'h200);
    chk("stall.count", 64'(bus.count), 64'd4);

    // Drop to count 3 then stream 20 cycles of write+read across the wrap point.
    tick("to3", 1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      tick("stream", 1'b1, 32'h300 + i, 32'h2000 + 32'(4 * i), 1'b1, 1'b0);
    chk("stream.count", 64'(bus.count), 64'd3);
    chk("stream.head", 64'(bus.rd_inst), 64'h311);

    // Build to 5 then flush with a competing write and read.
    tick("pre_fl", 1'b1, 32'h400, 32'h3000, 1'b0, 1'b0);
    tick("pre_fl", 1'b1, 32'h401, 32'h3004, 1'b0, 1'b0);
    chk("pre_fl.count", 64'(bus.count), 64'd5);
    tick("flush", 1'b1, 32'hF1F1, 32'hF1F0, 1'b1, 1'b1);
    chk_state("post_fl");
    tick("after_fl", 1'b1, 32'h500, 32'h4000, 1'b0, 1'b0);
    tick("after_fl", 1'b0, '0, '0, 1'b1, 1'b0);
    chk_state("after_fl_end");

    // Fill to 6, then assert reset between edges.
    for (int i = 0; i < 6; i++) tick("pre_rst", 1'b1, 32'h600 + i, 32'h5000 + 32'(4 * i), 1'b0, 1'b0);
    bus.wr_valid = 1'b1;
    bus.wr_inst  = 32'h5555;
    bus.wr_pc    = 32'h5550;
    #2 rst_n = 1'b1;
    #1;
    sb.delete();
    chk_state("mid_rst");
    @(posedge clk);
    #1;
    chk_state("rst_held");
    rst_n = 1'b0;
    tick("post_rst_wr", 1'b1, 32'hABCD, 32'h6000, 1'b0, 1'b0);
    chk("post_rst.head", 64'(bus.rd_inst), 64'hABCD);
    tick("post_rst_rd", 1'b0, '0, '0, 1'b1, 1'b0);
    chk_state("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_queue.md
INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

Interface
REQ-001 Parameter INST_WIDTH, default 32: width of one instruction word.
REQ-002 Parameter PC_WIDTH, default 32: width of the fetch address stored with each instruction.
REQ-003 Parameter DEPTH, default 8: number of entries; power of two, DEPTH >= 4.
REQ-004 Parameter AF_THRESH, default DEPTH-2: count at or above which almost_full asserts; range 1..DEPTH.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-high reset (asserted when 1).
REQ-007 flush  input  1  discard all queued entries (branch redirect / exception).
REQ-008 wr_valid  input  1  fetch stage presents an instruction.
REQ-009 wr_inst  input  INST_WIDTH  instruction word to enqueue.
REQ-010 wr_pc  input  PC_WIDTH  fetch address of wr_inst.
REQ-011 wr_ready  output  1  queue can accept a write this cycle.
REQ-012 rd_valid  output  1  head entry is valid for decode.
REQ-013 rd_ready  input  1  decode consumes the head entry this cycle (low = stall).
REQ-014 rd_inst  output  INST_WIDTH  head instruction word.
REQ-015 rd_pc  output  PC_WIDTH  head fetch address.
REQ-016 count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-017 empty, full, almost_full  output  1 each  status flags.

Function
REQ-018 Storage SHALL be a circular buffer of DEPTH entries {inst, pc}, with read and write pointers each $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
REQ-019 empty SHALL be 1 when the pointers are fully equal; full SHALL be 1 when the low bits are equal and the wrap bits differ.
REQ-020 count SHALL equal wr_ptr - rd_ptr modulo 2^($clog2(DEPTH)+1); almost_full SHALL equal (count >= AF_THRESH).
REQ-021 wr_ready SHALL equal !full and SHALL NOT depend on rd_ready (no write-through-on-full).
REQ-022 A write fires when wr_valid && wr_ready && !flush: the entry is stored at wr_ptr and wr_ptr increments.
REQ-023 rd_valid SHALL equal !empty; rd_inst/rd_pc SHALL combinationally show the entry at rd_ptr (first-word-fall-through, no read latency).
REQ-024 A read fires when rd_valid && rd_ready && !flush: rd_ptr increments; rd_ready while rd_valid is low SHALL have no effect.
REQ-025 Write-to-read latency SHALL be one cycle: an entry written at edge N is presented with rd_valid=1 after edge N.
REQ-026 Simultaneous read and write with 0 < count < DEPTH SHALL leave count unchanged and preserve FIFO order.
REQ-027 Read and write when full: the read fires and the write is refused (wr_ready=0); count becomes DEPTH-1.
REQ-028 Write when empty: the write fires and no read fires; count becomes 1.
REQ-029 Pointer wrap past DEPTH-1 SHALL toggle the wrap bit and SHALL NOT corrupt ordering or flags.
REQ-030 flush SHALL take priority over same-cycle reads and writes: at the next edge both pointers become 0; count=0, rd_valid=0, wr_ready=1.
REQ-031 rd_inst/rd_pc SHALL be don't-care while rd_valid=0; checkers SHALL NOT compare them.
REQ-032 Storage contents SHALL NOT be cleared by reset or flush; only the pointers are cleared.

Reset
REQ-033 While rst_n=1 (asynchronously, without waiting for a clock edge): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, rd_valid=0, wr_ready=1.
REQ-034 Reset asserted mid-operation SHALL discard all entries; the first write after deassertion SHALL be the first entry read.
REQ-035 Writes and reads SHALL NOT fire in any cycle in which rst_n=1.

Verification (DEPTH=8, AF_THRESH=6)
REQ-036 Fill: 8 writes, rd_ready=0 -> count 1..8; almost_full=1 from count 6; full=1 and wr_ready=0 at 8; a 9th write is ignored.
REQ-037 Drain order: write inst 0x100..0x107 with pc 0x0..0x1C, then read continuously -> same order out, one per cycle, then empty=1 and rd_valid=0.
REQ-038 Stall: rd_ready=0 for 3 cycles with count=4 -> rd_inst/rd_pc stable and count=4 throughout.
REQ-039 Wrap/streaming: 20 cycles of simultaneous write+read at count=3 -> count stays 3 and the output sequence matches the input sequence delayed by 3 entries.
REQ-040 Flush: count=5, flush=1 with wr_valid=1 and rd_ready=1 -> next cycle count=0, empty=1; the flushed-cycle write never appears on the output.
REQ-041 Async reset: assert rst_n between clock edges at count=6 -> count=0 and rd_valid=0 before the next edge; the first post-reset write 0xABCD appears at the head one cycle later.
